// File: rtl/lzc_unit.sv
// ---------------------------------------------------------------------------
// lzc_unit -- registered leading-zero counter for the BFloat16 datapath.
//
// Counts the zero bits of data_i above its highest set bit (MSB first) and
// registers the count one cycle later. Normalisation logic uses the count as
// a left-shift amount.
//
// Parameters
//   W       input data width, any W >= 1
//   CNT_W   count width, wide enough to hold 0..W
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous active-high reset
//   valid_i  in   1      data_i valid, captured on the clk edge
//   data_i   in   W      operand, bit W-1 is the MSB
//   valid_o  out  1      result registers hold a result captured last cycle
//   cnt_o    out  CNT_W  leading-zero count, 0..W (W for an all-zero operand)
//   zero_o   out  1      captured operand was all zeros
// ---------------------------------------------------------------------------
module lzc_unit #(
    parameter int W = 16,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [W-1:0]     data_i,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    // Tree depth and padded width. At least one level is kept so that the
    // tree count is never zero bits wide (matters for W = 1).
    localparam int LOG = (W <= 2) ? 1 : $clog2(W);
    localparam int P   = 1 << LOG;

    // Operand padded on the LSB side with ones up to P bits. The padding
    // sits below every real bit, so it can only terminate the count and an
    // all-zero operand naturally yields exactly W.
    logic [P-1:0] padded;

    generate
        if (P == W) begin : g_nopad
            assign padded = data_i;
        end else begin : g_pad
            assign padded = {data_i, {(P - W){1'b1}}};
        end
    endgenerate

    // Binary tree. Level gi has P>>gi nodes; each node covers 2^gi bits and
    // carries "has a set bit" (v) plus the leading-zero count within its span
    // (c, LOG bits per node, upper bits zero at shallow levels).
    // Merging two children: if the upper half has a one, its count wins;
    // otherwise the count is the full upper-half span (2^(gi-1)) plus the
    // lower half's count, which is an OR because the lower count is smaller.
    genvar gi, gj;
    generate
        for (gi = 0; gi <= LOG; gi++) begin : lvl
            localparam int N = P >> gi;
            logic [N-1:0]     v;
            logic [N*LOG-1:0] c;

            if (gi == 0) begin : g_leaf
                assign v = padded;
                assign c = '0;
            end else begin : g_node
                for (gj = 0; gj < N; gj++) begin : g_merge
                    logic hi_v;
                    logic lo_v;
                    logic [LOG-1:0] hi_c;
                    logic [LOG-1:0] lo_c;

                    assign hi_v = lvl[gi-1].v[2*gj+1];
                    assign lo_v = lvl[gi-1].v[2*gj];
                    assign hi_c = lvl[gi-1].c[(2*gj+1)*LOG +: LOG];
                    assign lo_c = lvl[gi-1].c[(2*gj)*LOG +: LOG];

                    assign v[gj] = hi_v | lo_v;
                    assign c[gj*LOG +: LOG] = hi_v ? hi_c
                                                   : (lo_c | LOG'(1 << (gi - 1)));
                end
            end
        end
    endgenerate

    logic [CNT_W-1:0] cnt_next;
    logic             zero_next;

    // Without padding the root only loses its "has a one" flag for an
    // all-zero operand; with padding the root is always set and already
    // counts W in that case.
    always_comb begin
        zero_next = ~|data_i;
        cnt_next  = CNT_W'(W);
        if (lvl[LOG].v[0]) begin
            cnt_next = CNT_W'(lvl[LOG].c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            cnt_o   <= '0;
            zero_o  <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                cnt_o  <= cnt_next;
                zero_o <= zero_next;
            end
        end
    end

endmodule

// File: tb/tb_lzc_unit.sv
// ---------------------------------------------------------------------------
// tb_lzc_unit -- directed testbench for lzc_unit.
//
// Main instance at W=16, plus W=1, 5 and 24 instances for the parameter
// sweep. Inputs change 1 time unit after a rising edge; outputs are checked
// 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_lzc_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // W = 16 instance
    logic        valid_i = 1'b0;
    logic [15:0] data_i  = '0;
    logic        valid_o;
    logic [4:0]  cnt_o;
    logic        zero_o;

    lzc_unit #(.W(16)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i),
        .valid_o(valid_o), .cnt_o(cnt_o), .zero_o(zero_o)
    );

    // Sweep instances
    logic        v1 = 1'b0, v5 = 1'b0, v24 = 1'b0;
    logic [0:0]  d1 = '0;
    logic [4:0]  d5 = '0;
    logic [23:0] d24 = '0;
    logic        vo1, vo5, vo24, z1, z5, z24;
    logic [0:0]  c1;
    logic [2:0]  c5;
    logic [4:0]  c24;

    lzc_unit #(.W(1)) dut_w1 (
        .clk(clk), .rst(rst), .valid_i(v1), .data_i(d1),
        .valid_o(vo1), .cnt_o(c1), .zero_o(z1)
    );
    lzc_unit #(.W(5)) dut_w5 (
        .clk(clk), .rst(rst), .valid_i(v5), .data_i(d5),
        .valid_o(vo5), .cnt_o(c5), .zero_o(z5)
    );
    lzc_unit #(.W(24)) dut_w24 (
        .clk(clk), .rst(rst), .valid_i(v24), .data_i(d24),
        .valid_o(vo24), .cnt_o(c24), .zero_o(z24)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Reference: plain MSB-first scan.
    function automatic int ref_lzc(input logic [31:0] d, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i]) return w - 1 - i;
        end
        return w;
    endfunction

    // Apply one W=16 operand, wait one edge, check the registered result.
    task automatic apply16(input string tag, input logic v, input logic [15:0] d,
                           input int exp_cnt, input logic exp_zero);
        valid_i = v;
        data_i  = d;
        @(posedge clk); #1;
        check({tag, " valid"}, 32'(valid_o), 32'(v));
        check({tag, " cnt"},   32'(cnt_o),   32'(exp_cnt));
        check({tag, " zero"},  32'(zero_o),  32'(exp_zero));
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] mask;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset cnt",   32'(cnt_o),   32'd0);
        check("reset zero",  32'(zero_o),  32'd0);
        rst = 1'b0;

        // Thermometer sweep
        apply16("therm FFFF", 1'b1, 16'hFFFF, 0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            d = (16'(1) << i) - 16'd1;
            apply16($sformatf("therm i=%0d", i), 1'b1, d, 16 - i, 1'b0);
        end

        // Zero operand then MSB set
        apply16("zero 0000", 1'b1, 16'h0000, 16, 1'b1);
        apply16("msb 8000",  1'b1, 16'h8000, 0,  1'b0);

        // One-hot walk, then with random low bits
        for (int k = 0; k < 16; k++) begin
            d = 16'(1) << k;
            apply16($sformatf("onehot k=%0d", k), 1'b1, d, 15 - k, 1'b0);
        end
        for (int k = 1; k < 16; k++) begin
            mask = (16'(1) << k) - 16'd1;
            d = (16'(1) << k) | (16'($urandom) & mask);
            apply16($sformatf("lowbits k=%0d", k), 1'b1, d, 15 - k, 1'b0);
        end
        apply16("00FF", 1'b1, 16'h00FF, 8, 1'b0);
        apply16("0080", 1'b1, 16'h0080, 8, 1'b0);

        // Valid gating: outputs hold while valid_i is low
        apply16("gate 0100",  1'b1, 16'h0100, 7,  1'b0);
        apply16("gate idle1", 1'b0, 16'hxxxx, 7,  1'b0);
        apply16("gate idle2", 1'b0, 16'hxxxx, 7,  1'b0);
        apply16("gate 0004",  1'b1, 16'h0004, 13, 1'b0);

        // Reset asserted mid-stream with a result pending
        valid_i = 1'b1;
        data_i  = 16'h0001;
        #2 rst = 1'b1;
        #1;
        check("rst async valid", 32'(valid_o), 32'd0);
        check("rst async cnt",   32'(cnt_o),   32'd0);
        check("rst async zero",  32'(zero_o),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst held valid", 32'(valid_o), 32'd0);
        check("rst held cnt",   32'(cnt_o),   32'd0);
        #2 rst = 1'b0;
        apply16("post rst 0001", 1'b1, 16'h0001, 15, 1'b0);
        valid_i = 1'b0;

        // Parameter sweep: W = 1, 5, 24
        for (int t = 0; t < 24; t++) begin
            v1 = 1'b1; v5 = 1'b1; v24 = 1'b1;
            if (t == 0) begin
                d1 = '0; d5 = '0; d24 = '0;
            end else begin
                d1  = 1'($urandom);
                // Shift random data right by a varying amount to reach deep counts.
                d5  = 5'($urandom) >> (t % 6);
                d24 = 24'($urandom) >> (t % 25);
            end
            @(posedge clk); #1;
            check($sformatf("w1 d=%0h cnt", d1),   32'(c1),  32'(ref_lzc(32'(d1), 1)));
            check($sformatf("w1 d=%0h zero", d1),  32'(z1),  32'(d1 == '0));
            check($sformatf("w5 d=%0h cnt", d5),   32'(c5),  32'(ref_lzc(32'(d5), 5)));
            check($sformatf("w5 d=%0h zero", d5),  32'(z5),  32'(d5 == '0));
            check($sformatf("w24 d=%0h cnt", d24), 32'(c24), 32'(ref_lzc(32'(d24), 24)));
            check($sformatf("w24 d=%0h zero", d24), 32'(z24), 32'(d24 == '0));
            check("sweep valid", 32'({vo1, vo5, vo24}), 32'd7);
        end
        v1 = 1'b0; v5 = 1'b0; v24 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
